// File: rtl/computation_pkg.sv
// Shared types for the computation sequencer: FSM states, engine modes and
// the packed 2x2 result layout exchanged with computation_module.
package computation_pkg;

  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned RESULT_W = 4 * ELEM_W;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP,
    RUN_SINGLE,
    RUN_SA3,
    RUN_SA2,
    FINISH
  } seq_state_t;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SINGLE = 2'd0;
  localparam mode_t MODE_SA3    = 2'd1;
  localparam mode_t MODE_SA2    = 2'd2;
  localparam mode_t MODE_ALL    = 2'd3;

  // {c11,c12,c21,c22}, c11 in the most significant byte
  typedef struct packed {
    logic [ELEM_W-1:0] c11;
    logic [ELEM_W-1:0] c12;
    logic [ELEM_W-1:0] c21;
    logic [ELEM_W-1:0] c22;
  } c_mat_t;

endpackage

// File: rtl/computation_sequencer_if.sv
// Phase handshake and result bus between the sequencer and computation_module.
interface computation_sequencer_if;
  import computation_pkg::*;

  logic   active_send;
  logic   active_single;
  logic   active_sa3;
  logic   active_sa2;
  logic   done_send;
  logic   done_single;
  logic   done_sa3;
  logic   done_sa2;
  c_mat_t c_in;

  modport master (
    output active_send, active_single, active_sa3, active_sa2,
    input  done_send, done_single, done_sa3, done_sa2, c_in
  );

  modport slave (
    input  active_send, active_single, active_sa3, active_sa2,
    output done_send, done_single, done_sa3, done_sa2, c_in
  );

endinterface

// File: rtl/computation_sequencer_phase_timer.sv
// Per-phase cycle counter: cleared on state entry, saturating, with a
// combinational flag once the count has reached TIMEOUT.
module phase_timer #(
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             timeout_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign timeout_c = (cnt >= CNT_W'(TIMEOUT));

endmodule

// File: rtl/computation_sequencer.sv
// Host-facing control FSM that walks computation_module through send and
// compute phases, captures results/latency and cross-checks engines in mode 3.
module computation_sequencer
  import computation_pkg::*;
#(
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  mode_t                   mode,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    mismatch,
  output c_mat_t                  result,
  output logic [CNT_W-1:0]        last_cycles,
  computation_sequencer_if.master eng
);

  seq_state_t            state_q, state_d;
  seq_state_t            prev_q, prev_d;
  mode_t                 mode_q;
  logic [RESULT_W-1:0]   single_q;
  logic [CNT_W-1:0]      cnt;
  logic                  timeout_c;
  logic                  clear_c;
  logic                  accept_c;
  logic                  capture_c;
  logic                  store_c;
  logic                  compare_c;
  logic                  abort_c;
  logic                  act_send_q, act_single_q, act_sa3_q, act_sa2_q;

  phase_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_c),
    .cnt       (cnt),
    .timeout_c (timeout_c)
  );

  // Next state and per-cycle datapath strobes; a matching done beats timeout.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    store_c   = 1'b0;
    compare_c = 1'b0;
    abort_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (eng.done_send) begin
          state_d = GAP;
          prev_d  = SEND;
        end else if (timeout_c) begin
          abort_c = 1'b1;
          state_d = FINISH;
        end
      end
      GAP: begin
        state_d = FINISH;
        unique case (prev_q)
          SEND: begin
            unique case (mode_q)
              MODE_SINGLE, MODE_ALL: state_d = RUN_SINGLE;
              MODE_SA3:              state_d = RUN_SA3;
              MODE_SA2:              state_d = RUN_SA2;
              default:               state_d = FINISH;
            endcase
          end
          RUN_SINGLE: if (mode_q == MODE_ALL) state_d = RUN_SA3;
          RUN_SA3:    if (mode_q == MODE_ALL) state_d = RUN_SA2;
          default:    state_d = FINISH;
        endcase
      end
      RUN_SINGLE: begin
        if (eng.done_single) begin
          capture_c = 1'b1;
          store_c   = (mode_q == MODE_ALL);
          state_d   = GAP;
          prev_d    = RUN_SINGLE;
        end else if (timeout_c) begin
          abort_c = 1'b1;
          state_d = FINISH;
        end
      end
      RUN_SA3: begin
        if (eng.done_sa3) begin
          capture_c = 1'b1;
          compare_c = (mode_q == MODE_ALL);
          state_d   = GAP;
          prev_d    = RUN_SA3;
        end else if (timeout_c) begin
          abort_c = 1'b1;
          state_d = FINISH;
        end
      end
      RUN_SA2: begin
        if (eng.done_sa2) begin
          capture_c = 1'b1;
          compare_c = (mode_q == MODE_ALL);
          state_d   = GAP;
          prev_d    = RUN_SA2;
        end else if (timeout_c) begin
          abort_c = 1'b1;
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    clear_c = (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prev_q  <= IDLE;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  // Outputs are decoded from the next state so they line up with state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= MODE_SINGLE;
      single_q     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      mismatch     <= 1'b0;
      result       <= '0;
      last_cycles  <= '0;
      act_send_q   <= 1'b0;
      act_single_q <= 1'b0;
      act_sa3_q    <= 1'b0;
      act_sa2_q    <= 1'b0;
    end else begin
      if (accept_c) begin
        mode_q   <= mode;
        error    <= 1'b0;
        mismatch <= 1'b0;
      end
      if (abort_c) error <= 1'b1;
      if (capture_c) begin
        result      <= eng.c_in;
        last_cycles <= cnt;
      end
      if (store_c) single_q <= eng.c_in;
      if (compare_c && (eng.c_in != single_q)) mismatch <= 1'b1;
      busy         <= (state_d != IDLE) && (state_d != FINISH);
      done         <= (state_d == FINISH);
      act_send_q   <= (state_d == SEND);
      act_single_q <= (state_d == RUN_SINGLE);
      act_sa3_q    <= (state_d == RUN_SA3);
      act_sa2_q    <= (state_d == RUN_SA2);
    end
  end

  assign eng.active_send   = act_send_q;
  assign eng.active_single = act_single_q;
  assign eng.active_sa3    = act_sa3_q;
  assign eng.active_sa2    = act_sa2_q;

endmodule

// File: tb/tb_computation_sequencer.sv
// Directed bench for computation_sequencer with a latency-programmable mock
// of computation_module; expected values are hand-computed per step.
module tb_computation_sequencer;
  import computation_pkg::*;

  localparam int unsigned TIMEOUT = 63;
  localparam int unsigned CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  mode_t            mode;
  logic             busy, done, error, mismatch;
  c_mat_t           result;
  logic [CNT_W-1:0] last_cycles;

  computation_sequencer_if eng ();

  computation_sequencer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .mismatch    (mismatch),
    .result      (result),
    .last_cycles (last_cycles),
    .eng         (eng)
  );

  always #5 clk = ~clk;

  // Mock engine: done_x fires once active_x has been sampled lat_x times.
  int          lat_send, lat_single, lat_sa3, lat_sa2;
  int          cnt_send, cnt_single, cnt_sa3, cnt_sa2;
  logic        stray_sa2;
  logic [31:0] c_base, c_sa2;

  always @(posedge clk) begin
    cnt_send   <= eng.active_send   ? cnt_send + 1   : 0;
    cnt_single <= eng.active_single ? cnt_single + 1 : 0;
    cnt_sa3    <= eng.active_sa3    ? cnt_sa3 + 1    : 0;
    cnt_sa2    <= eng.active_sa2    ? cnt_sa2 + 1    : 0;
  end

  assign eng.done_send   = eng.active_send   && (cnt_send   == lat_send);
  assign eng.done_single = eng.active_single && (cnt_single == lat_single);
  assign eng.done_sa3    = eng.active_sa3    && (cnt_sa3    == lat_sa3);
  assign eng.done_sa2    = (eng.active_sa2   && (cnt_sa2    == lat_sa2)) || stray_sa2;
  assign eng.c_in        = c_mat_t'(eng.active_sa2 ? c_sa2 : c_base);

  int total = 0;
  int bad   = 0;

  // Observations gathered while a job runs
  int          w_cycles, w_gaps, w_dones, w_sa3_cyc;
  logic [31:0] w_trace;
  logic        w_busy_at_done, w_err_at_done, w_seen_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] act_code();
    return {eng.active_send, eng.active_single, eng.active_sa3, eng.active_sa2};
  endfunction

  task automatic start_job(input mode_t m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follow a job until done plus a short tail; bounded by budget cycles.
  task automatic wait_job(input int budget);
    logic [3:0] prev, code;
    int         tail;
    prev = 4'h0; w_trace = '0; w_cycles = 0; w_gaps = 0; w_dones = 0;
    w_sa3_cyc = 0; w_seen_done = 1'b0; w_busy_at_done = 1'bx; w_err_at_done = 1'bx;
    tail = 0;
    code = act_code();
    while (w_cycles < budget && tail < 5) begin
      if (code != prev) begin
        w_trace = {w_trace[27:0], code};
        prev    = code;
      end
      if (busy && code == 4'h0) w_gaps++;
      if (eng.active_sa3) w_sa3_cyc++;
      if (done) begin
        w_dones++;
        if (!w_seen_done) begin
          w_busy_at_done = busy;
          w_err_at_done  = error;
        end
        w_seen_done = 1'b1;
      end
      if (w_seen_done) tail++;
      @(negedge clk);
      w_cycles++;
      code = act_code();
    end
    check("job_finished_in_budget", 32'(w_seen_done), 32'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = MODE_SINGLE; stray_sa2 = 1'b0;
    lat_send = 1; lat_single = 36; lat_sa3 = 16; lat_sa2 = 28;
    c_base = 32'h24362436; c_sa2 = 32'h24362436;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_busy",        32'(busy),        32'd0);
    check("reset_done",        32'(done),        32'd0);
    check("reset_error",       32'(error),       32'd0);
    check("reset_result",      32'(result),      32'd0);
    check("reset_last_cycles", 32'(last_cycles), 32'd0);

    // 1: asynchronous reset while SEND is stalled
    lat_send = 1000;
    start_job(MODE_SINGLE);
    repeat (2) @(negedge clk);
    check("send_active_before_reset", 32'(act_code()), 32'h8);
    check("busy_before_reset",        32'(busy),       32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_drop_actives", 32'(act_code()), 32'h0);
    check("async_drop_busy",    32'(busy),       32'd0);
    @(negedge clk);
    rst = 1'b1;
    lat_send = 1;
    w_dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || act_code() != 4'h0 || busy) w_dones++;
    end
    check("idle_after_reset_quiet", 32'(w_dones), 32'd0);
    check("mismatch_after_reset",   32'(mismatch), 32'd0);

    // 2: mode 0, single latency 36
    start_job(MODE_SINGLE);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_job(300);
    check("m0_result",        32'(result),         32'h24362436);
    check("m0_last_cycles",   32'(last_cycles),    32'd36);
    check("m0_error",         32'(w_err_at_done),  32'd0);
    check("m0_busy_at_done",  32'(w_busy_at_done), 32'd0);
    check("m0_done_pulses",   32'(w_dones),        32'd1);
    check("m0_trace",         w_trace,             32'h0000_8040);

    // 3: mode 3, all engines agree
    start_job(MODE_ALL);
    wait_job(400);
    check("m3_trace",       w_trace,          32'h8040_2010);
    check("m3_gap_cycles",  32'(w_gaps),      32'd4);
    check("m3_last_cycles", 32'(last_cycles), 32'd28);
    check("m3_mismatch",    32'(mismatch),    32'd0);
    check("m3_error",       32'(error),       32'd0);
    check("m3_result",      32'(result),      32'h24362436);

    // 4: mode 3, sa2 disagrees in c22
    c_sa2 = 32'h24362437;
    start_job(MODE_ALL);
    wait_job(400);
    check("m3_bad_mismatch", 32'(mismatch), 32'd1);
    check("m3_bad_result",   32'(result),   32'h24362437);
    c_sa2 = 32'h24362436;

    // 5: mode 1, sa3 never completes -> timeout abort
    lat_sa3 = 1000;
    start_job(MODE_SA3);
    check("m1_start_clears_mismatch", 32'(mismatch), 32'd0);
    wait_job(300);
    check("to_error_with_done", 32'(w_err_at_done), 32'd1);
    check("to_done_pulses",     32'(w_dones),       32'd1);
    check("to_sa3_window", 32'((w_sa3_cyc >= int'(TIMEOUT)) && (w_sa3_cyc <= int'(TIMEOUT) + 1)), 32'd1);
    check("to_actives_low",     32'(act_code()),    32'h0);
    check("to_error_held",      32'(error),         32'd1);
    lat_sa3 = 16;

    // 6: extra starts and a stray done_sa2 while RUN_SINGLE is active
    lat_single = 20;
    start_job(MODE_SINGLE);
    repeat (4) @(negedge clk);
    check("in_run_single", 32'(act_code()), 32'h4);
    start = 1'b1; mode = MODE_SA2; stray_sa2 = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0; stray_sa2 = 1'b0;
    wait_job(300);
    check("ign_done_pulses",  32'(w_dones),     32'd1);
    check("ign_trace",        w_trace,          32'h0000_0040);
    check("ign_last_cycles",  32'(last_cycles), 32'd20);
    check("ign_error_clear",  32'(error),       32'd0);

    // 7: done in the very first active cycle -> zero latency
    lat_single = 0;
    c_base = 32'h01020304;
    start_job(MODE_SINGLE);
    wait_job(100);
    check("zero_last_cycles", 32'(last_cycles), 32'd0);
    check("zero_result",      32'(result),      32'h01020304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
